// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame/baud constants.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_BITS    = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10416;
    localparam int unsigned DEFAULT_STOP_BITS    = 1;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; push is refused when full,
// pop is ignored when empty, head entry visible on rdata without a pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queue in a FIFO and are sent as start, LSB-first
// data and STOP_BITS stop bits; frames run back-to-back while the FIFO has data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = DEFAULT_STOP_BITS,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          i_reset_n,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 baud_end;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (i_reset_n),
        .push  (i_valid),
        .wdata (i_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    assign o_ready  = !fifo_full;
    assign o_busy   = (state_q != IDLE) || !fifo_empty;
    assign o_tx     = tx_q;
    assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level for the next cycle, so o_tx follows state changes with no skew.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            tx_d     = 1'b0;
                            state_d  = START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule
